// File: rtl/bus_addr_decoder_if.sv
// Master-port and slave-port signal bundle of the multi-slave address decoder.
// master: CPU side driving requests; slave: the decoder, which owns the slave-facing outputs.
interface bus_addr_decoder_if #(
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                             m_req;
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic                             m_we;
    logic [DATA_WIDTH-1:0]            m_wdata;
    logic                             m_rdy;
    logic                             m_ack;
    logic                             m_err;
    logic [DATA_WIDTH-1:0]            m_rdata;

    logic [N_SLAVES-1:0]              s_req;
    logic [ADDR_WIDTH-1:0]            s_addr;
    logic                             s_we;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [N_SLAVES-1:0]              s_ack;
    logic [N_SLAVES*DATA_WIDTH-1:0]   s_rdata;

    modport master (
        output m_req, m_addr, m_we, m_wdata,
        input  m_rdy, m_ack, m_err, m_rdata
    );

    modport slave (
        input  m_req, m_addr, m_we, m_wdata, s_ack, s_rdata,
        output m_rdy, m_ack, m_err, m_rdata, s_req, s_addr, s_we, s_wdata
    );
endinterface

// File: rtl/bus_addr_decoder.sv
// Registered N-window address decoder: one transaction at a time, one-hot slave request, ack or timeout.
// Miss completes in 1 cycle, hit in ack delay + 1; m_rdy low from acceptance until after the response.
module bus_addr_decoder #(
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASEADDRS =
        {32'h8000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] WORDS =
        {32'h0000_0010, 32'h0000_0400, 32'h0000_0100, 32'h0000_0400},
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_addr_decoder_if.slave    bus
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel;
    logic [CNT_W-1:0]        cnt;

    logic [ADDR_WIDTH:0]     diff [N_SLAVES];
    logic [N_SLAVES-1:0]     hit;
    logic                    dec_any;
    logic [SEL_W-1:0]        dec_sel;
    logic [N_SLAVES-1:0]     dec_oh;
    logic [ADDR_WIDTH-1:0]   dec_off;
    logic                    sel_ack;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // A one-bit-wider difference goes "negative" (huge) when the address is
    // below the base, so a single unsigned compare checks both window edges
    // and a window ending at the top of the address space cannot wrap.
    for (genvar g = 0; g < N_SLAVES; g++) begin : g_win
        localparam logic [ADDR_WIDTH-1:0] BASE = BASEADDRS[g*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] SIZE = WORDS[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign diff[g] = {1'b0, bus.m_addr} - {1'b0, BASE};
        assign hit[g]  = diff[g] < {1'b0, SIZE};
    end

    // Descending scan so the lowest matching index has the final say.
    always_comb begin
        dec_any = 1'b0;
        dec_sel = '0;
        dec_oh  = '0;
        dec_off = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_any    = 1'b1;
                dec_sel    = SEL_W'(i);
                dec_oh     = '0;
                dec_oh[i]  = 1'b1;
                dec_off    = diff[i][ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ack   = bus.s_ack[i];
                sel_rdata = bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.m_rdy = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            bus.s_req   <= '0;
            bus.s_addr  <= '0;
            bus.s_we    <= 1'b0;
            bus.s_wdata <= '0;
            bus.m_ack   <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.m_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.m_ack   <= 1'b0;
                    bus.m_err   <= 1'b0;
                    bus.m_rdata <= '0;
                    if (bus.m_req) begin
                        bus.s_addr  <= dec_off;
                        bus.s_we    <= bus.m_we;
                        bus.s_wdata <= bus.m_wdata;
                        cnt         <= '0;
                        sel         <= dec_sel;
                        if (dec_any) begin
                            bus.s_req <= dec_oh;
                            state     <= BUSY;
                        end else begin
                            bus.m_ack <= 1'b1;
                            bus.m_err <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ack is checked first so it beats a simultaneous timeout.
                    if (sel_ack) begin
                        bus.s_req   <= '0;
                        bus.m_ack   <= 1'b1;
                        bus.m_err   <= 1'b0;
                        bus.m_rdata <= bus.s_we ? '0 : sel_rdata;
                        state       <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.s_req   <= '0;
                        bus.m_ack   <= 1'b1;
                        bus.m_err   <= 1'b1;
                        bus.m_rdata <= '0;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    bus.m_ack   <= 1'b0;
                    bus.m_err   <= 1'b0;
                    bus.m_rdata <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
- Registered, multi-slave successor to the single-region address decoder.
- Accepts one master transaction at a time and decodes it against N_SLAVES independently parametrised address windows.
- Forwards the relative word offset to the selected slave, then waits for that slave's acknowledge.
- Returns read data, or an error on an unmapped address or a timeout.
- Sits between the CPU/master port and the memory/peripheral slaves.

Parameters:
- N_SLAVES, 4, number of slave windows (1..16).
- ADDR_WIDTH, 32, address bits on the master and slave sides.
- DATA_WIDTH, 32, data bits.
- BASEADDRS, {32'h8000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}, N_SLAVES*ADDR_WIDTH concatenated bases; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- WORDS, {32'h10, 32'h400, 32'h100, 32'h400}, N_SLAVES*ADDR_WIDTH concatenated window sizes; 0 disables that slave.
- TIMEOUT, 16, maximum cycles spent waiting for S_ACK (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- M_REQ  in  1  master request, sampled only while M_RDY=1.
- M_ADDR  in  ADDR_WIDTH  absolute master address.
- M_WE  in  1  1=write, 0=read.
- M_WDATA  in  DATA_WIDTH  write data.
- M_RDY  out  1  decoder idle and able to accept a request.
- M_ACK  out  1  one-cycle completion pulse.
- M_ERR  out  1  qualifies M_ACK as an error completion.
- M_RDATA  out  DATA_WIDTH  read data, valid while M_ACK=1.
- S_REQ  out  N_SLAVES  one-hot request to slaves.
- S_ADDR  out  ADDR_WIDTH  offset, M_ADDR minus BASE of the selected slave.
- S_WE  out  1  registered copy of M_WE.
- S_WDATA  out  DATA_WIDTH  registered copy of M_WDATA.
- S_ACK  in  N_SLAVES  per-slave acknowledge.
- S_RDATA  in  N_SLAVES*DATA_WIDTH  concatenated per-slave read data.

Behaviour:
- Reset: state IDLE; S_REQ=0, S_ADDR=0, S_WE=0, S_WDATA=0, M_ACK=0, M_ERR=0, M_RDATA=0, timeout counter=0. M_RDY=(state==IDLE), so it reads 1 during reset, but no request is accepted while RST=1.
- Decode: hit_i = (BASE_i <= M_ADDR) && (M_ADDR < BASE_i+WORDS_i).
  - The sum is computed at ADDR_WIDTH+1 bits, so a window touching the top of the address space does not wrap.
  - WORDS_i=0 never hits.
  - Overlapping windows: the lowest index wins; S_REQ is always one-hot or zero.
- IDLE:
  - On a rising edge with M_REQ=1: register the offset, M_WE and M_WDATA; clear the counter.
  - Any hit: go to BUSY and assert S_REQ[i] from the next cycle.
  - No hit: go to RESP with M_ERR pending; no S_REQ is issued.
- BUSY:
  - S_REQ[i], S_ADDR, S_WE and S_WDATA are held stable.
  - The counter increments every cycle.
  - S_ACK[i] sampled high: capture S_RDATA slice i (0 for writes), drop S_REQ, go to RESP with no error.
  - Otherwise, counter==TIMEOUT-1: drop S_REQ, go to RESP with error.
  - S_ACK and the timeout in the same cycle: the ACK wins.
  - S_ACK bits from non-selected slaves are ignored.
- RESP: M_ACK=1 for exactly one cycle, with M_ERR and M_RDATA (0 on error) valid; next state is IDLE. M_ACK, M_ERR and M_RDATA return to 0 in IDLE.
- Latency, request accepted at edge t:
  - Unmapped address: M_ACK high in cycle t+1.
  - Hit: S_REQ high from cycle t+1.
  - ACK sampled at edge t+k (k>=1): M_ACK high in cycle t+k+1.
  - Best case: ACK during cycle t+1, so M_ACK in cycle t+2.
  - Timeout: M_ACK in cycle t+TIMEOUT+1.
- Back-to-back: M_RDY=0 in BUSY and RESP. The next request is accepted at the first edge after RESP, giving a minimum spacing of 3 cycles for a hit.
- Reset mid-transaction: S_REQ and M_ACK clear immediately (asynchronously); the in-flight transaction is abandoned with no response.

Test Plan:
- Read with M_ADDR=0x0000_1010: S_REQ=4'b0010, S_ADDR=0x10, S_WE=0. Slave 1 ACKs after 3 cycles with 0xDEAD_BEEF -> one M_ACK pulse, M_ERR=0, M_RDATA=0xDEAD_BEEF.
- Window edges:
  - M_ADDR=0x0000_03FF -> slave 0, offset 0x3FF.
  - M_ADDR=0x0000_0400 -> M_ACK with M_ERR=1 in cycle t+1; S_REQ never asserted.
  - M_ADDR=0x8000_000F -> slave 3, offset 0xF.
- Timeout: M_ADDR=0x0000_2004 with S_ACK held at 0 -> S_REQ=4'b0100 for 16 cycles; M_ACK with M_ERR=1 and M_RDATA=0 in cycle t+17.
- Stray ACK: S_ACK=4'b0001 while slave 2 is selected -> ignored. Then S_ACK=4'b0100 on the counter's final cycle -> completion with M_ERR=0 (ACK beats timeout).
- Write 0x1234_5678 to 0x0000_1000 -> S_WDATA=0x1234_5678, S_WE=1. After the ACK, M_RDATA=0 and M_RDY=1 in the cycle after M_ACK.
- RST pulsed while in BUSY -> S_REQ=0 with no clock edge needed, M_ACK never asserts, and a new request is accepted normally after reset releases.
